// File: rtl/ram2e_pkg.sv
// Shared state encodings, the C073 address and default parameter values for the
// second-generation RAM2E DRAM sequencer.
package ram2e_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_VRAS    = 4'd1,
    S_VCAS    = 4'd2,
    S_VLATCH  = 4'd3,
    S_VCAS2   = 4'd4,
    S_REF     = 4'd5,
    S_RA_HI   = 4'd6,
    S_CPU_RAS = 4'd7,
    S_RA_LO   = 4'd8,
    S_RD_CAS  = 4'd9,
    S_S10     = 4'd10,
    S_WR_CAS  = 4'd11,
    S_S12     = 4'd12,
    S_BANKLD  = 4'd13,
    S_S14     = 4'd14,
    S_HOLD    = 4'd15
  } state_t;

  localparam logic [3:0] C073_ADDR = 4'h3;

  localparam int DEF_BANK_BITS  = 6;
  localparam int DEF_RA_HI_BITS = 4;
  localparam int DEF_REF_PERIOD = 13;

  function automatic logic state_in(input logic [3:0] s, input logic [3:0] lo,
                                    input logic [3:0] hi);
    return (s >= lo) && (s <= hi);
  endfunction

endpackage

// File: rtl/ram2e_phi_sync.sv
// PHI1 rising-edge detector and 16-state sequence counter aligned to each PHI1 rise.
// No sync is produced after reset until PHI1 has been seen low once.
module ram2e_phi_sync
  import ram2e_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       phi1,
  output logic [3:0] state,
  output logic       sync
);

  state_t s_q;
  logic   phi1_q;
  logic   phi0_seen;

  assign sync  = phi1 & ~phi1_q & phi0_seen;
  assign state = s_q;

  // A sync restarts the sequence even mid-cycle; otherwise idle holds and 15 saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= S_IDLE;
      phi1_q    <= 1'b0;
      phi0_seen <= 1'b0;
    end else begin
      phi1_q <= phi1;
      if (!phi1)
        phi0_seen <= 1'b1;
      if (sync)
        s_q <= S_VRAS;
      else if (s_q == S_IDLE)
        s_q <= S_IDLE;
      else if (s_q == S_HOLD)
        s_q <= S_HOLD;
      else
        s_q <= state_t'(s_q + 4'd1);
    end
  end

endmodule

// File: rtl/ram2e_seq_gen2.sv
// RAM2E gen-2 DRAM sequencer and bank controller (nRAS/nCAS/RA/VDLE, C073 bank register).
// Define RAM2E_BANK_READBACK_EN to enable reading the bank register back through C073.
module ram2e_seq_gen2
  import ram2e_pkg::*;
#(
  parameter int BANK_BITS  = DEF_BANK_BITS,
  parameter int RA_HI_BITS = DEF_RA_HI_BITS,
  parameter int REF_PERIOD = DEF_REF_PERIOD
) (
  input  logic                  C14M,
  input  logic                  RST,
  input  logic                  PHI1,
  input  logic                  nPRAS,
  input  logic                  nWE,
  input  logic                  nWE80,
  input  logic                  nC07X,
  input  logic [3:0]            MA,
  input  logic [7:0]            MDI,
  output logic                  nRAS,
  output logic                  nCAS,
  output logic                  nRWE,
  output logic [RA_HI_BITS-1:0] RA,
  output logic                  VDLE,
  output logic [BANK_BITS-1:0]  BA,
  output logic                  BAOE,
  output logic [7:0]            BAOUT
);

  localparam logic [3:0] REF_LAST = 4'(REF_PERIOD - 1);

  logic [3:0] s;
  logic       sync;
  logic [3:0] ref_cnt;
  logic       ref_due;
  logic       wr_sel;
  logic       c073_hit;
  logic       ras_req;
  logic       cas_low;
  logic       cas_high;
  logic [7:0] ba_ext;
  logic [7:0] ba_hi_full;
  logic       unused_bits;

  ram2e_phi_sync u_phi_sync (
    .clk   (C14M),
    .rst   (RST),
    .phi1  (PHI1),
    .state (s),
    .sync  (sync)
  );

  assign nRWE     = nWE80;
  assign VDLE     = (s == S_VLATCH);
  assign ref_due  = (ref_cnt == 4'd0);
  assign c073_hit = ~nC07X & (MA == C073_ADDR);

  // Upper bank bits go out first on RA, then the low bits during the CPU access.
  assign ba_ext     = 8'(BA);
  assign ba_hi_full = ba_ext >> RA_HI_BITS;

  assign ras_req = sync | (s == S_VRAS) | (s == S_VCAS)
                 | ((s == S_REF) & ref_due)
                 | state_in(s, S_CPU_RAS, S_WR_CAS);

  assign cas_low  = (s == S_VCAS) | (s == S_VCAS2)
                  | ((s == S_RD_CAS) & nWE80)
                  | ((s == S_WR_CAS) & ~nWE80);
  assign cas_high = (s == S_IDLE) | (s == S_VLATCH) | nPRAS;

  always_ff @(posedge C14M or posedge RST) begin
    if (RST) begin
      ref_cnt <= 4'd0;
      BA      <= '0;
      wr_sel  <= 1'b0;
      nRAS    <= 1'b1;
      nCAS    <= 1'b1;
      RA      <= '0;
    end else begin
      if (s == S_VRAS)
        ref_cnt <= (ref_cnt == REF_LAST) ? 4'd0 : ref_cnt + 4'd1;

      if (s == S_CPU_RAS)
        wr_sel <= c073_hit & ~nWE;
      if ((s == S_BANKLD) && wr_sel)
        BA <= MDI[BANK_BITS-1:0];

      nRAS <= ~ras_req;

      if (cas_high)
        nCAS <= 1'b1;
      else if (cas_low)
        nCAS <= 1'b0;

      if (state_in(s, S_RA_HI, S_CPU_RAS))
        RA <= ba_hi_full[RA_HI_BITS-1:0];
      else if (state_in(s, S_RA_LO, S_WR_CAS))
        RA <= ba_ext[RA_HI_BITS-1:0];
      else
        RA <= '0;
    end
  end

`ifdef RAM2E_BANK_READBACK_EN
  logic rd_sel;

  // The read select lives for one PHI1 cycle and is dropped on the next sync.
  always_ff @(posedge C14M or posedge RST) begin
    if (RST)
      rd_sel <= 1'b0;
    else if (sync)
      rd_sel <= 1'b0;
    else if (s == S_CPU_RAS)
      rd_sel <= c073_hit & nWE;
  end

  assign BAOE  = rd_sel & state_in(s, S_RA_LO, S_BANKLD);
  assign BAOUT = ba_ext;
`else
  assign BAOE  = 1'b0;
  assign BAOUT = 8'h00;
`endif

  assign unused_bits = ^{MDI, ba_hi_full};

endmodule
